// File: rtl/hud_overlay.sv
// HUD/text overlay: score, high score, level, title, flashing prompt and end-of-game banners.
// Two-cycle pixel pipeline feeding an external glyph ROM; define HUD_HISCORE_EN to include the high score.
module hud_overlay #(
  parameter int          SCORE_DIGITS = 3,
  parameter int          FLASH_BITS   = 24,
  parameter logic [5:0]  FG_COLOR     = 6'b110000,
  parameter logic [5:0]  BG_COLOR     = 6'b000000,
  parameter int          X_LEFT       = 96,
  parameter int          X_RIGHT      = 544,
  parameter int          HUD_SCALE    = 2,
  parameter int          TITLE_SCALE  = 7,
  parameter int          BANNER_SCALE = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                state,
  input  logic [3:0]                level,
  input  logic [9:0]                col_pos,
  input  logic [9:0]                row_pos,
  input  logic                      btn_up_tick,
  input  logic                      btn_down_tick,
  output logic [7:0]                glyph_char,
  output logic [9:0]                glyph_row,
  input  logic [7:0]                glyph_bits,
  output logic [5:0]                color,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [4*SCORE_DIGITS-1:0] hiscore_bcd
);

  localparam int SW = 4 * SCORE_DIGITS;
  localparam logic [1:0] ST_MENU    = 2'd0;
  localparam logic [1:0] ST_PLAYING = 2'd1;
  localparam logic [1:0] ST_DEAD    = 2'd2;
  localparam logic [1:0] ST_WIN     = 2'd3;
  localparam logic [SW-1:0] ALL9 = {SCORE_DIGITS{4'h9}};

`ifdef HUD_HISCORE_EN
  localparam int SC_CHARS = 8 + 2 * SCORE_DIGITS;
`else
  localparam int SC_CHARS = 4 + SCORE_DIGITS;
`endif
  localparam int SC_X0 = X_LEFT + 5;
  localparam int SC_Y0 = 5;
  localparam int HUD_H = 8 * HUD_SCALE;
  localparam int LV_X0 = X_RIGHT - 5 - 5 * 8 * HUD_SCALE;
  localparam int TT_X0 = X_LEFT + 224 - 28 * TITLE_SCALE;
  localparam int TT_Y0 = 190 - 5 * TITLE_SCALE;
  localparam int PR_X0 = 320 - 11 * 8 * HUD_SCALE;
  localparam int PR_Y0 = 330;
  localparam int GO_X0 = 320 - (9 * 8 * BANNER_SCALE) / 2;
  localparam int YW_X0 = 320 - (7 * 8 * BANNER_SCALE) / 2;
  localparam int BN_Y0 = 180;

  localparam logic [191:0] S_TITLE  = {136'd0, "FROGGER"};
  localparam logic [191:0] S_PROMPT = {16'd0, "PRESS ANY KEY TO START"};
  localparam logic [191:0] S_OVER   = {120'd0, "GAME OVER"};
  localparam logic [191:0] S_WIN    = {136'd0, "YOU WIN"};
  localparam logic [31:0]  S_PTS    = "PTS:";
  localparam logic [31:0]  S_HI     = " HI:";
  localparam logic [31:0]  S_LVL    = "LVL:";

  function automatic logic in_box(input int c, input int r, input int x0, input int y0,
                                  input int w, input int h);
    return (c >= x0) && (c < x0 + w) && (r >= y0) && (r < y0 + h);
  endfunction

  function automatic logic [7:0] pick(input logic [191:0] s, input int n, input int idx);
    return s[8*(n-1-idx) +: 8];
  endfunction

  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          cy;
    r  = v;
    cy = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (cy) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          cy = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [9:0]            progress_q, progress_d;
  logic [SW-1:0]         score_q, score_d;
  logic [13:0]           score_bin_q, score_bin_d;
  logic [SW-1:0]         hiscore_q;
  logic [FLASH_BITS-1:0] flash_tmr_q, flash_tmr_d;
  logic                  flash_q, flash_d;
  logic                  prev_menu_q;

  function automatic logic [7:0] score_char(input int idx, input logic [SW-1:0] sc,
                                            input logic [SW-1:0] hi);
    logic [7:0] c;
    c = 8'h20;
    if (idx < 4)
      c = S_PTS[8*(3-idx) +: 8];
    else if (idx < 4 + SCORE_DIGITS)
      c = {4'h3, sc[4*(SCORE_DIGITS-1-(idx-4)) +: 4]};
    else if (idx < 8 + SCORE_DIGITS)
      c = S_HI[8*(7+SCORE_DIGITS-idx) +: 8];
    else
      c = {4'h3, hi[4*(SCORE_DIGITS-1-(idx-8-SCORE_DIGITS)) +: 4]};
    return c;
  endfunction

  function automatic logic [7:0] level_char(input int idx, input logic [3:0] lv);
    logic [7:0] c;
    if (idx < 4)
      c = S_LVL[8*(3-idx) +: 8];
    else if (lv < 4'd10)
      c = {4'h3, lv};
    else
      c = 8'h41 + {4'h0, lv - 4'd10};
    return c;
  endfunction

  always_comb begin
    progress_d = progress_q;
    if (state == ST_MENU)
      progress_d = '0;
    else if (state == ST_PLAYING && (btn_up_tick ^ btn_down_tick)) begin
      if (btn_up_tick)
        progress_d = progress_q + 10'd1;
      else if (progress_q != 10'd0)
        progress_d = progress_q - 10'd1;
    end

    score_d     = score_q;
    score_bin_d = score_bin_q;
    if (state == ST_MENU) begin
      score_d     = '0;
      score_bin_d = '0;
    end else if ({4'd0, progress_q} > score_bin_q && score_q != ALL9) begin
      score_d     = bcd_inc(score_q);
      score_bin_d = score_bin_q + 14'd1;
    end

    // Entering MENU restarts the blink with the prompt shown.
    flash_tmr_d = flash_tmr_q + 1'b1;
    flash_d     = flash_q;
    if (state == ST_MENU && !prev_menu_q) begin
      flash_tmr_d = '0;
      flash_d     = 1'b1;
    end else if (flash_tmr_q == '1) begin
      flash_d = ~flash_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      progress_q  <= '0;
      score_q     <= '0;
      score_bin_q <= '0;
      flash_tmr_q <= '0;
      flash_q     <= 1'b1;
      prev_menu_q <= 1'b0;
    end else begin
      progress_q  <= progress_d;
      score_q     <= score_d;
      score_bin_q <= score_bin_d;
      flash_tmr_q <= flash_tmr_d;
      flash_q     <= flash_d;
      prev_menu_q <= (state == ST_MENU);
    end
  end

`ifdef HUD_HISCORE_EN
  // Unsigned compare on packed BCD matches a most-significant-digit-first compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hiscore_q <= '0;
    else if (score_q > hiscore_q)
      hiscore_q <= score_q;
  end
`else
  assign hiscore_q = '0;
`endif

  logic       hit_d, hit_q;
  logic [7:0] char_d, char_q;
  logic [9:0] row_d, row_q;
  logic [2:0] bit_d, bit_q;
  logic [5:0] color_q;
  int         cx, ry, lx, ly;

  always_comb begin
    cx     = int'(col_pos);
    ry     = int'(row_pos);
    lx     = 0;
    ly     = 0;
    hit_d  = 1'b0;
    char_d = 8'h00;
    if (in_box(cx, ry, SC_X0, SC_Y0, SC_CHARS * HUD_H, HUD_H)) begin
      lx = (cx - SC_X0) / HUD_SCALE;  ly = (ry - SC_Y0) / HUD_SCALE;
      char_d = score_char(lx / 8, score_q, hiscore_q);
      hit_d  = 1'b1;
    end else if (in_box(cx, ry, LV_X0, SC_Y0, 5 * HUD_H, HUD_H)) begin
      lx = (cx - LV_X0) / HUD_SCALE;  ly = (ry - SC_Y0) / HUD_SCALE;
      char_d = level_char(lx / 8, level);
      hit_d  = 1'b1;
    end else if (state == ST_MENU &&
                 in_box(cx, ry, TT_X0, TT_Y0, 56 * TITLE_SCALE, 8 * TITLE_SCALE)) begin
      lx = (cx - TT_X0) / TITLE_SCALE;  ly = (ry - TT_Y0) / TITLE_SCALE;
      char_d = pick(S_TITLE, 7, lx / 8);
      hit_d  = 1'b1;
    end else if (state == ST_MENU && flash_q &&
                 in_box(cx, ry, PR_X0, PR_Y0, 22 * HUD_H, HUD_H)) begin
      lx = (cx - PR_X0) / HUD_SCALE;  ly = (ry - PR_Y0) / HUD_SCALE;
      char_d = pick(S_PROMPT, 22, lx / 8);
      hit_d  = 1'b1;
    end else if (state == ST_DEAD &&
                 in_box(cx, ry, GO_X0, BN_Y0, 72 * BANNER_SCALE, 8 * BANNER_SCALE)) begin
      lx = (cx - GO_X0) / BANNER_SCALE;  ly = (ry - BN_Y0) / BANNER_SCALE;
      char_d = pick(S_OVER, 9, lx / 8);
      hit_d  = 1'b1;
    end else if (state == ST_WIN &&
                 in_box(cx, ry, YW_X0, BN_Y0, 56 * BANNER_SCALE, 8 * BANNER_SCALE)) begin
      lx = (cx - YW_X0) / BANNER_SCALE;  ly = (ry - BN_Y0) / BANNER_SCALE;
      char_d = pick(S_WIN, 7, lx / 8);
      hit_d  = 1'b1;
    end
    row_d = 10'(ly);
    bit_d = 3'd7 - 3'(lx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q   <= 1'b0;
      char_q  <= '0;
      row_q   <= '0;
      bit_q   <= '0;
      color_q <= BG_COLOR;
    end else begin
      hit_q   <= hit_d;
      char_q  <= char_d;
      row_q   <= row_d;
      bit_q   <= bit_d;
      color_q <= (hit_q && glyph_bits[bit_q]) ? FG_COLOR : BG_COLOR;
    end
  end

  assign glyph_char  = char_q;
  assign glyph_row   = row_q;
  assign color       = color_q;
  assign score_bcd   = score_q;
  assign hiscore_bcd = hiscore_q;

endmodule

// File: doc/hud_overlay.md
# hud_overlay

Parametrised HUD/text overlay generator for the Frogger VGA pipeline. It tracks score and persistent high score, and renders the score, level, title and flashing prompt, plus state-dependent GAME OVER / YOU WIN banners. Glyph bitmaps come from the external `text_gen` ROM through a fixed two-cycle pixel pipeline. It sits between the VGA timing counters and the final colour mux.

## Interface

Parameters:
- `SCORE_DIGITS`, 3: BCD digits for score and high score (1–4).
- `FLASH_BITS`, 24: prompt toggles every 2^FLASH_BITS cycles.
- `FG_COLOR`, 6'b110000: colour of set glyph pixels.
- `BG_COLOR`, 6'b000000: colour everywhere else.
- `X_LEFT`, 96: left playfield edge (pixels).
- `X_RIGHT`, 544: right playfield edge (pixels).
- `HUD_SCALE`, 2: integer scale of score, level and prompt text.
- `TITLE_SCALE`, 7: integer scale of the title.
- `BANNER_SCALE`, 5: integer scale of the GAME OVER / YOU WIN banners.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `state` in 2: 0 MENU, 1 PLAYING, 2 DEAD, 3 WIN.
- `level` in 4: current level.
- `col_pos` in 10: current pixel column.
- `row_pos` in 10: current pixel row.
- `btn_up_tick` in 1: one-cycle up press.
- `btn_down_tick` in 1: one-cycle down press.
- `glyph_char` out 8: ASCII code to `text_gen`.
- `glyph_row` out 10: glyph row to `text_gen`.
- `glyph_bits` in 8: `text_gen` bitmap, combinational from `glyph_char`/`glyph_row`. MSB is the leftmost pixel.
- `color` out 6: pixel colour.
- `score_bcd` out 4*SCORE_DIGITS: current score.
- `hiscore_bcd` out 4*SCORE_DIGITS: high score.

## Operation

- **Progress counter** (10-bit binary):
  - Cleared while `state`==MENU.
  - In PLAYING, an up tick adds 1 and a down tick subtracts 1, saturating at 0.
  - Both ticks in the same cycle: no change.
  - Ticks are ignored in MENU, DEAD and WIN.
- **Score** (BCD):
  - Cleared while in MENU.
  - Increments by 1 in the cycle after progress exceeds score, i.e. on a new maximum.
  - Saturates at all-9s.
- **High score** (BCD):
  - Cleared only by `rst_n`; survives MENU.
  - In any cycle where score > hiscore (MSB-first digit compare), hiscore <= score.
- **Flash:**
  - `FLASH_BITS`-bit free-running timer; flag toggles when the timer wraps to 0.
  - On entry to MENU (previous state ≠ MENU), timer cleared and flag set, so the prompt is visible immediately.
- **Regions**, priority high to low; each text is drawn only inside its box:
  - Score: x=X_LEFT+5, y=5, HUD_SCALE, text "PTS:" + SCORE_DIGITS digits + " HI:" + SCORE_DIGITS digits.
  - Level: right edge X_RIGHT-5, y=5, HUD_SCALE, text "LVL:" + hex digit (10–15 shown as A–F).
  - MENU only: title "FROGGER", TITLE_SCALE, x=X_LEFT+224-28*TITLE_SCALE, y=190-5*TITLE_SCALE.
  - MENU only, while the flash flag is set: prompt "PRESS ANY KEY TO START", HUD_SCALE, horizontally centred on 320, y=330.
  - DEAD only: "GAME OVER", BANNER_SCALE, centred on x=320, y=180.
  - WIN only: "YOU WIN", BANNER_SCALE, centred on x=320, y=180.
- **Glyph addressing:** local x = (col_pos − box_x)/scale, local y = (row_pos − box_y)/scale. Character index = local x[..3]; bit = 7 − local x[2:0].
- **Colour:** FG_COLOR when inside a region and the selected bit is 1, else BG_COLOR.

## Timing

- **Stage 1** (registered at cycle N+1 from inputs at N): `glyph_char`, `glyph_row`, bit select, hit flag.
- **Stage 2** (N+2): `color` registered from `glyph_bits`[bit select] & hit.
- Pixel latency is exactly 2 cycles; the caller delays sync signals to match.
- Counter, score and hiscore updates take effect 1 cycle after the tick or compare.
- Rendered digits reflect the register values at stage-1 time.
- **Reset values:**
  - `color`=BG_COLOR, `glyph_char`=0, `glyph_row`=0.
  - Score, hiscore and progress = 0.
  - Flash flag = 1, flash timer = 0.
  - Pipeline hit flags = 0.
- **State change mid-frame:** region selection follows `state` per pixel; no frame-boundary synchronisation.

## Configuration

- `HUD_HISCORE_EN` defined:
  - Hiscore register, compare logic and the " HI:ddd" text are present.
  - `hiscore_bcd` tracks as above.
- Undefined:
  - Hiscore logic is removed, the score field ends after the score digits, and that area renders BG_COLOR.
  - `hiscore_bcd` is tied to 0.

## Test plan

- Reset, `state`=PLAYING, 5 up ticks then 2 down ticks → progress 3, `score_bcd`=0x005; with `HUD_HISCORE_EN`, `hiscore_bcd`=0x005.
- `state`=MENU, then PLAYING, 3 up ticks → score 0x003, hiscore stays 0x005. Down ticks at progress 0 → progress stays 0.
- Preload progress/score to 999, then up tick → score stays 0x999. Up and down ticks in the same cycle → no change.
- `col_pos`=X_LEFT+5, `row_pos`=5 in the score box with `glyph_bits`=0x80 → `glyph_char`="P" at N+1, `color`=FG_COLOR at N+2. With `glyph_bits`=0x00 → BG_COLOR.
- MENU with FLASH_BITS=4 → prompt pixel visible for 16 cycles, then blank for 16; re-entering MENU shows it immediately.
- `state`=DEAD, pixel inside the banner → "GAME OVER" characters addressed, title and prompt never addressed. `state`=WIN → "YOU WIN".
